// File: rtl/vga_pixel_mixer.sv
// vga_pixel_mixer
// Colour stage between the VGA timing / game logic and the DAC. Each pixel
// is black during blanking, a palette colour for game pixels, or a
// monochrome ROM pixel (optionally inverted). One palette code can blink
// from a free-running half-period counter. Two registered stages on
// clock_25. Reset is synchronous and active-low.
module vga_pixel_mixer #(
  parameter int COLOR_BITS = 10,
  parameter int CODE_BITS  = 2,
  parameter int BLINK_HALF = 12500000,
  parameter int BLINK_CODE = 2
) (
  input  logic                      clock_25,
  input  logic                      resetn,
  input  logic                      display_area,
  input  logic                      game_enable,
  input  logic [CODE_BITS-1:0]      game_data,
  input  logic                      datarom,
  input  logic                      text_invert,
  input  logic                      blink_en,
  input  logic                      pal_we,
  input  logic [CODE_BITS-1:0]      pal_addr,
  input  logic [3*COLOR_BITS-1:0]   pal_rgb,
  output logic [COLOR_BITS-1:0]     red,
  output logic [COLOR_BITS-1:0]     green,
  output logic [COLOR_BITS-1:0]     blue,
  output logic                      video_active
);

  localparam int PAL_DEPTH = 1 << CODE_BITS;
  localparam int RGB_W     = 3 * COLOR_BITS;
  // A one-cycle half period still needs a one-bit counter.
  localparam int CNT_W     = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(BLINK_HALF - 1);
  localparam logic [CODE_BITS-1:0] BLINK_SEL = CODE_BITS'(BLINK_CODE);

  // Reset colour of palette entry idx: black, green, red, white, then black.
  function automatic logic [RGB_W-1:0] pal_default(input int idx);
    logic [COLOR_BITS-1:0] m;
    logic [COLOR_BITS-1:0] z;
    logic [RGB_W-1:0]      v;
    m = '1;
    z = '0;
    case (idx)
      32'sd0:  v = {z, z, z};
      32'sd1:  v = {z, m, z};
      32'sd2:  v = {m, z, z};
      32'sd3:  v = {m, m, m};
      default: v = {z, z, z};
    endcase
    return v;
  endfunction

  // Run-time writable palette.
  logic [RGB_W-1:0]     r_pal [PAL_DEPTH];

  // Blink generator state.
  logic [CNT_W-1:0]     r_blink_cnt;
  logic                 r_blink_phase;

  // Stage-1 pipeline registers.
  logic                 r_s1_display;
  logic                 r_s1_game;
  logic [CODE_BITS-1:0] r_s1_code;
  logic                 r_s1_rom;
  logic                 r_s1_invert;
  logic                 r_s1_blink;

  // Stage-2 (output) registers.
  logic [COLOR_BITS-1:0] r_red;
  logic [COLOR_BITS-1:0] r_green;
  logic [COLOR_BITS-1:0] r_blue;
  logic                  r_video_active;

  // Combinational stage-2 colour selection.
  logic                 w_blink_hit;
  logic [CODE_BITS-1:0] w_pal_idx;
  logic [RGB_W-1:0]     w_rgb;

  // Palette storage: defaults on reset, otherwise one write per cycle.
  always_ff @(posedge clock_25) begin
    if (!resetn) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        r_pal[i] <= pal_default(i);
      end
    end else if (pal_we) begin
      r_pal[pal_addr] <= pal_rgb;
    end
  end

  // Free-running blink counter; the phase flips each time it wraps.
  always_ff @(posedge clock_25) begin
    if (!resetn) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == CNT_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + CNT_W'(1);
      r_blink_phase <= r_blink_phase;
    end
  end

  // Blink applies only to the selected code, while enabled, in the "off" phase.
  always_comb begin
    w_blink_hit = 1'b0;
    if (blink_en && r_blink_phase && (game_data == BLINK_SEL)) begin
      w_blink_hit = 1'b1;
    end else begin
      w_blink_hit = 1'b0;
    end
  end

  // Stage 1: capture pixel attributes and the gated blink flag.
  always_ff @(posedge clock_25) begin
    if (!resetn) begin
      r_s1_display <= 1'b0;
      r_s1_game    <= 1'b0;
      r_s1_code    <= '0;
      r_s1_rom     <= 1'b0;
      r_s1_invert  <= 1'b0;
      r_s1_blink   <= 1'b0;
    end else begin
      r_s1_display <= display_area;
      r_s1_game    <= game_enable;
      r_s1_code    <= game_data;
      r_s1_rom     <= datarom;
      r_s1_invert  <= text_invert;
      r_s1_blink   <= w_blink_hit;
    end
  end

  // A blinking pixel shows palette entry 0 instead of its own code.
  always_comb begin
    w_pal_idx = r_s1_code;
    if (r_s1_blink) begin
      w_pal_idx = '0;
    end else begin
      w_pal_idx = r_s1_code;
    end
  end

  // Colour selection: blanking wins, then game palette, then ROM pixel.
  always_comb begin
    w_rgb = '0;
    if (!r_s1_display) begin
      w_rgb = '0;
    end else if (r_s1_game) begin
      w_rgb = r_pal[w_pal_idx];
    end else if (r_s1_rom ^ r_s1_invert) begin
      w_rgb = '1;
    end else begin
      w_rgb = '0;
    end
  end

  // Stage 2: register the DAC drive and the aligned active flag.
  always_ff @(posedge clock_25) begin
    if (!resetn) begin
      r_red          <= '0;
      r_green        <= '0;
      r_blue         <= '0;
      r_video_active <= 1'b0;
    end else begin
      r_red          <= w_rgb[3*COLOR_BITS-1:2*COLOR_BITS];
      r_green        <= w_rgb[2*COLOR_BITS-1:COLOR_BITS];
      r_blue         <= w_rgb[COLOR_BITS-1:0];
      r_video_active <= r_s1_display;
    end
  end

  assign red          = r_red;
  assign green        = r_green;
  assign blue         = r_blue;
  assign video_active = r_video_active;

endmodule

// File: tb/tb_vga_pixel_mixer.sv
// Self-checking bench for vga_pixel_mixer (BLINK_HALF shortened to 4).
// A reference model predicts every output cycle from the pixel rules:
// pixels are held in a queue and resolved two edges after entry, blink
// phase is derived arithmetically from the edge count since reset.
module tb_vga_pixel_mixer;

  localparam int CB = 10;
  localparam int KB = 2;
  localparam int H  = 4;
  localparam int BC = 2;

  logic          clock_25 = 1'b0;
  logic          resetn;
  logic          display_area;
  logic          game_enable;
  logic [KB-1:0] game_data;
  logic          datarom;
  logic          text_invert;
  logic          blink_en;
  logic          pal_we;
  logic [KB-1:0] pal_addr;
  logic [3*CB-1:0] pal_rgb;
  logic [CB-1:0] red, green, blue;
  logic          video_active;

  vga_pixel_mixer #(
    .COLOR_BITS(CB), .CODE_BITS(KB), .BLINK_HALF(H), .BLINK_CODE(BC)
  ) dut (
    .clock_25(clock_25), .resetn(resetn), .display_area(display_area),
    .game_enable(game_enable), .game_data(game_data), .datarom(datarom),
    .text_invert(text_invert), .blink_en(blink_en), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_rgb(pal_rgb), .red(red), .green(green),
    .blue(blue), .video_active(video_active)
  );

  always #5 clock_25 = ~clock_25;

  typedef struct {
    bit       da;
    bit       ge;
    bit [1:0] code;
    bit       rom;
    bit       inv;
    bit       blink_off;   // pixel falls in an "off" blink half-period
  } pix_t;

  int checks = 0;
  int errors = 0;

  // Reference state.
  logic [3*CB-1:0] m_pal [4];
  pix_t            m_q[$];        // pixels accepted but not yet shown
  int              m_edges;       // non-reset edges since last reset
  logic [CB-1:0]   e_r, e_g, e_b;
  logic            e_va;

  function automatic logic [3*CB-1:0] rgb3(input logic [CB-1:0] r,
                                           input logic [CB-1:0] g,
                                           input logic [CB-1:0] b);
    return {r, g, b};
  endfunction

  task automatic model_reset_palette();
    logic [CB-1:0] m;
    logic [CB-1:0] z;
    m = '1;
    z = '0;
    m_pal[0] = rgb3(z, z, z);
    m_pal[1] = rgb3(z, m, z);
    m_pal[2] = rgb3(m, z, z);
    m_pal[3] = rgb3(m, m, m);
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    pix_t p;
    logic [3*CB-1:0] c;
    if (!resetn) begin
      m_q.delete();
      e_r = '0; e_g = '0; e_b = '0; e_va = 1'b0;
      model_reset_palette();
      m_edges = 0;
    end else begin
      // Pixel that entered one edge ago is coloured now, with today's palette.
      if (m_q.size() > 0) begin
        p = m_q.pop_front();
        if (!p.da)                c = '0;
        else if (p.ge)            c = p.blink_off ? m_pal[0] : m_pal[p.code];
        else if (p.rom != p.inv)  c = '1;
        else                      c = '0;
        e_r = c[29:20]; e_g = c[19:10]; e_b = c[9:0]; e_va = p.da;
      end else begin
        // Stage 1 still holds its reset value: a blanked pixel.
        e_r = '0; e_g = '0; e_b = '0; e_va = 1'b0;
      end
      p.da = display_area; p.ge = game_enable; p.code = game_data;
      p.rom = datarom; p.inv = text_invert;
      p.blink_off = blink_en && (((m_edges / H) % 2) == 1) && (game_data == 2'(BC));
      m_q.push_back(p);
      if (pal_we) m_pal[pal_addr] = pal_rgb;
      m_edges++;
    end
  endtask

  // One clock: model and DUT advance together, outputs checked 1 time unit later.
  task automatic tick(input string tag);
    @(posedge clock_25);
    model_edge();
    #1;
    checks++;
    assert ({red, green, blue, video_active} === {e_r, e_g, e_b, e_va})
    else begin
      errors++;
      $error("FAIL %s: observed rgb=%h/%h/%h va=%b expected rgb=%h/%h/%h va=%b",
             tag, red, green, blue, video_active, e_r, e_g, e_b, e_va);
    end
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    resetn = 1'b0; display_area = 1'b0; game_enable = 1'b0; game_data = 2'd0;
    datarom = 1'b0; text_invert = 1'b0; blink_en = 1'b0; pal_we = 1'b0;
    pal_addr = 2'd0; pal_rgb = 30'd0;
    model_reset_palette();
    m_edges = 0;
    e_r = '0; e_g = '0; e_b = '0; e_va = 1'b0;

    // Reset state.
    ticks(2, "reset");
    resetn = 1'b1;

    // Default palette streamed through the game path.
    display_area = 1'b1; game_enable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      game_data = 2'(c);
      tick("palette_default");
    end
    ticks(2, "palette_drain");

    // ROM path with and without inversion.
    game_enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      text_invert = k[1];
      datarom     = ~k[0];
      tick("rom_pixel");
    end
    ticks(2, "rom_drain");

    // Blanking beats the game path.
    display_area = 1'b0; game_enable = 1'b1; game_data = 2'd3;
    ticks(4, "blanking");

    // Palette write while code 1 streams, then reset restores green.
    display_area = 1'b1; game_data = 2'd1;
    ticks(3, "pal_pre_write");
    pal_we = 1'b1; pal_addr = 2'd1; pal_rgb = rgb3(10'h155, 10'h0AA, 10'h001);
    tick("pal_write_edge");
    pal_we = 1'b0;
    ticks(4, "pal_post_write");
    resetn = 1'b0;
    pal_we = 1'b1; pal_rgb = rgb3(10'h3FF, 10'h000, 10'h3FF);
    tick("pal_reset_dominates");
    pal_we = 1'b0; resetn = 1'b1;
    ticks(4, "pal_restored");

    // Blink on code 2, then disabled, then code 1 unaffected.
    resetn = 1'b0;
    tick("blink_reset");
    resetn = 1'b1; game_data = 2'd2; blink_en = 1'b1;
    ticks(20, "blink_code2");
    blink_en = 1'b0;
    ticks(10, "blink_disabled");
    blink_en = 1'b1; game_data = 2'd1;
    ticks(10, "blink_other_code");

    // Reset mid-blink: output blanks, phase restarts.
    game_data = 2'd2;
    ticks(6, "midblink_run");
    resetn = 1'b0;
    tick("midblink_reset");
    resetn = 1'b1;
    ticks(14, "midblink_resume");

    // Randomized traffic including palette writes and occasional resets.
    for (int i = 0; i < 600; i++) begin
      resetn       = ($urandom_range(0, 59) != 0);
      display_area = ($urandom_range(0, 7) != 0);
      game_enable  = $urandom_range(0, 1) == 1;
      game_data    = 2'($urandom_range(0, 3));
      datarom      = $urandom_range(0, 1) == 1;
      text_invert  = $urandom_range(0, 1) == 1;
      blink_en     = ($urandom_range(0, 3) != 0);
      pal_we       = ($urandom_range(0, 7) == 0);
      pal_addr     = 2'($urandom_range(0, 3));
      pal_rgb      = 30'($urandom);
      tick("random");
    end
    resetn = 1'b1; pal_we = 1'b0;
    ticks(3, "final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pixel_mixer.md
# vga_pixel_mixer

Parametrised pixel colour stage between the timing generator / game logic and the VGA DAC. Per pixel it selects black (blanking), a game-board colour from a run-time writable palette, or a monochrome text/bitmap pixel from the image ROM. It adds a free-running blink generator for one palette code and an optional text inversion mode. It is a registered two-stage pipeline on the pixel clock.

## Interface
- COLOR_BITS, 10, width of each colour channel output.
- CODE_BITS, 2, width of game colour code; palette has 2^CODE_BITS entries.
- BLINK_HALF, 12500000, blink half-period in clock_25 cycles (must be ≥1).
- BLINK_CODE, 2, palette code affected by blinking.

- clock_25  in  1  pixel clock; the only clock.
- resetn  in  1  synchronous, active-low reset.
- display_area  in  1  1 = visible pixel.
- game_enable  in  1  1 = pixel comes from game_data, 0 = from datarom.
- game_data  in  CODE_BITS  palette index for the current pixel.
- datarom  in  1  monochrome ROM pixel.
- text_invert  in  1  1 = swap ROM foreground/background.
- blink_en  in  1  1 = blinking active for BLINK_CODE.
- pal_we  in  1  palette write strobe, one entry per cycle.
- pal_addr  in  CODE_BITS  palette entry written.
- pal_rgb  in  3*COLOR_BITS  {red, green, blue} written.
- red, green, blue  out  COLOR_BITS each  registered DAC drive.
- video_active  out  1  display_area delayed to align with the colour outputs.

## Operation
- Stage 1 registers display_area, game_enable, game_data, datarom, text_invert, and the gated blink flag (blink_en & blink_phase & game_data==BLINK_CODE).
- Stage 2 computes the colour from the stage-1 values and registers it into red/green/blue/video_active:
  - !display_area: all channels 0.
  - game_enable: palette[code], except blink flag set → palette[0].
  - !game_enable: (datarom XOR text_invert) ? all channels all-ones : all channels 0.
- Palette reset defaults, where M = all-ones: entry 0 = (0,0,0); entry 1 = (0,M,0); entry 2 = (M,0,0); entry 3 = (M,M,M); entries ≥4 = (0,0,0). For CODE_BITS=1, only entries 0 and 1 exist.
- Palette write: when pal_we=1 at an edge, palette[pal_addr] ← pal_rgb. Writes are accepted every cycle with no back-pressure and are independent of display_area.
- Blink generator: counter 0..BLINK_HALF-1, free-running. At terminal count the counter wraps to 0 and blink_phase toggles. It runs regardless of blink_en. Deasserting blink_en suppresses the effect only; it does not clear the phase.

## Timing
- Latency: input at edge N → outputs valid after edge N+2. video_active carries the same 2-cycle delay.
- Reset (resetn=0 sampled at an edge) clears:
  - red/green/blue and video_active → 0,
  - pipeline registers → 0,
  - blink counter and blink_phase → 0,
  - palette → defaults.
- Reset dominates pal_we in the same cycle. Reset mid-frame blanks output from the next edge; the first valid colour appears 2 cycles after resetn rises.
- Write/read collision: the palette is read when stage 2 registers. A write at edge N is visible to a stage-2 lookup at edge N+1 or later; a lookup at edge N sees the old value.
- Blink phase is sampled in stage 1, so a phase toggle affects pixels entering at the following edge.
- Simultaneous display_area=0 and game_enable=1 → black (blanking wins).

## Test plan
- Reset, then stream display_area=1, game_enable=1, codes 0,1,2,3 → two cycles later outputs (0,0,0), (0,3FF,0), (3FF,0,0), (3FF,3FF,3FF); video_active=1.
- game_enable=0, datarom 1,0 with text_invert=0 then 1 → (3FF,3FF,3FF), 0, then 0, (3FF,3FF,3FF).
- display_area=0 with game_enable=1, code=3 → outputs 0, video_active=0.
- pal_we=1, addr=1, rgb=(155,0AA,001) while code 1 streams → old green for lookups up to the write edge, then (155,0AA,001) from the next lookup; apply reset → green restored.
- BLINK_HALF=4, blink_en=1, constant code 2 → output alternates 4 cycles red / 4 cycles black. With blink_en=0 it stays red; code 1 is never affected.
- Assert resetn=0 mid-stream and mid-blink → outputs 0 after one edge; after release, colours resume at +2 cycles and the blink phase restarts from 0.
